register_bank: RTL and testbench

- Parametrised successor to the single 16-bit FunSel register: a bank of NUM_REGS registers of WIDTH bits.
- Every enabled register executes a common 4-bit function select in the same cycle.
- Two combinational read ports.
- Registered Zero/Carry status taken from the lowest-indexed enabled register.
- Intended as the general-purpose/address register group feeding the ALU and memory-address paths.

---
 rtl/register_pkg.sv | 29 ++
 rtl/register_slice.sv | 81 ++++++++
 rtl/register_bank.sv | 94 +++++++++
 tb/tb_register_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared definitions for the register bank: function-select codes and the
// helper that decides which operations update the status flags.
package register_pkg;

  typedef logic [3:0] funsel_t;

  localparam funsel_t FS_DEC    = 4'b0000;
  localparam funsel_t FS_INC    = 4'b0001;
  localparam funsel_t FS_LOAD   = 4'b0010;
  localparam funsel_t FS_CLEAR  = 4'b0011;
  localparam funsel_t FS_LOADLZ = 4'b0100;
  localparam funsel_t FS_WRLO   = 4'b0101;
  localparam funsel_t FS_WRHI   = 4'b0110;
  localparam funsel_t FS_LOADLS = 4'b0111;
  localparam funsel_t FS_SHL    = 4'b1000;
  localparam funsel_t FS_SHR    = 4'b1001;
  localparam funsel_t FS_ASR    = 4'b1010;
  localparam funsel_t FS_ROL    = 4'b1011;
  localparam funsel_t FS_ROR    = 4'b1100;
  localparam funsel_t FS_SWAP   = 4'b1101;
  localparam funsel_t FS_HOLD   = 4'b1110;
  localparam funsel_t FS_RSVD   = 4'b1111;

  // HOLD and the reserved code leave both registers and flags untouched.
  function automatic logic fs_updates_flags(input funsel_t fs);
    return !((fs == FS_HOLD) || (fs == FS_RSVD));
  endfunction

endpackage

// File: rtl/register_slice.sv
// One bank register plus its next-value and carry-out logic. The next value
// is exported even when the slice is disabled so the bank can source flags.
module register_slice
  import register_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  funsel_t          fun_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next,
  output logic             carry_next
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
    q_next     = q_q;
    carry_next = 1'b0;
    case (fun_sel)
      FS_DEC: begin
        q_next     = q_q - WIDTH'(1);
        carry_next = (q_q == '0);
      end
      FS_INC: begin
        q_next     = q_q + WIDTH'(1);
        carry_next = &q_q;
      end
      FS_LOAD:   q_next = data_in;
      FS_CLEAR:  q_next = '0;
      FS_LOADLZ: q_next = {{HALF{1'b0}}, data_in[HALF-1:0]};
      FS_WRLO:   q_next = {q_q[WIDTH-1:HALF], data_in[HALF-1:0]};
      FS_WRHI:   q_next = {data_in[HALF-1:0], q_q[HALF-1:0]};
      FS_LOADLS: q_next = {{HALF{data_in[HALF-1]}}, data_in[HALF-1:0]};
      FS_SHL: begin
        q_next     = {q_q[WIDTH-2:0], 1'b0};
        carry_next = q_q[WIDTH-1];
      end
      FS_SHR: begin
        q_next     = {1'b0, q_q[WIDTH-1:1]};
        carry_next = q_q[0];
      end
      FS_ASR: begin
        q_next     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        carry_next = q_q[0];
      end
      FS_ROL: begin
        q_next     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        carry_next = q_q[WIDTH-1];
      end
      FS_ROR: begin
        q_next     = {q_q[0], q_q[WIDTH-1:1]};
        carry_next = q_q[0];
      end
      FS_SWAP:   q_next = {q_q[HALF-1:0], q_q[WIDTH-1:HALF]};
      default:   q_next = q_q;
    endcase
  end

  assign q_d = en ? q_next : q_q;

  // NOTE: state flops use non-blocking assignment so every slice samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers sharing one function select, with two
// combinational read ports and Zero/Carry flags from the lowest enabled slice.
module register_bank
  import register_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              SEL_W       = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  funsel_t             FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] RegEn,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic                Zero,
  output logic                Carry
);

  logic [WIDTH-1:0]    q_arr      [NUM_REGS];
  logic [WIDTH-1:0]    q_next_arr [NUM_REGS];
  logic [NUM_REGS-1:0] carry_next_vec;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_slice
    register_slice #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_slice (
      .clk        (Clock),
      .rst_n      (Reset),
      .en         (RegEn[k]),
      .fun_sel    (FunSel),
      .data_in    (I),
      .q          (q_arr[k]),
      .q_next     (q_next_arr[k]),
      .carry_next (carry_next_vec[k])
    );
  end

  // Selects past the last register read as zero rather than aliasing.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SEL_W'(k)) OutA = q_arr[k];
      if (OutBSel == SEL_W'(k)) OutB = q_arr[k];
    end
  end

  logic [WIDTH-1:0] src_next;
  logic             src_carry;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  // Scanning downward lets the lowest enabled index win the flag source.
  always_comb begin
    src_next  = '0;
    src_carry = 1'b0;
    for (int k = NUM_REGS - 1; k >= 0; k--) begin
      if (RegEn[k]) begin
        src_next  = q_next_arr[k];
        src_carry = carry_next_vec[k];
      end
    end
  end

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if ((|RegEn) && fs_updates_flags(FunSel)) begin
      zero_d  = (src_next == '0);
      carry_d = src_carry;
    end
  end

  // NOTE: only these few control flops and the bank registers take reset; there is no memory array here to leave unreset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign Zero  = zero_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus queues expected reads/flags,
// a negedge monitor pops and compares. Two builds: 16x4 and 8x3.
module tb_register_bank;
  import register_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  // 16-bit, 4-register build with a non-zero reset value
  funsel_t     FunSel0 = FS_HOLD;
  logic [15:0] I0      = '0;
  logic [3:0]  RegEn0  = '0;
  logic [1:0]  OutASel0 = '0, OutBSel0 = '0;
  logic [15:0] OutA0, OutB0;
  logic        Zero0, Carry0;

  // 8-bit, 3-register build
  funsel_t     FunSel1 = FS_HOLD;
  logic [7:0]  I1      = '0;
  logic [2:0]  RegEn1  = '0;
  logic [1:0]  OutASel1 = '0, OutBSel1 = '0;
  logic [7:0]  OutA1, OutB1;
  logic        Zero1, Carry1;

  register_bank #(.WIDTH(16), .NUM_REGS(4), .RESET_VALUE(16'h00A5)) dut0 (
    .Clock(Clock), .Reset(Reset), .FunSel(FunSel0), .I(I0), .RegEn(RegEn0),
    .OutASel(OutASel0), .OutBSel(OutBSel0), .OutA(OutA0), .OutB(OutB0),
    .Zero(Zero0), .Carry(Carry0)
  );

  register_bank #(.WIDTH(8), .NUM_REGS(3), .RESET_VALUE(8'h00)) dut1 (
    .Clock(Clock), .Reset(Reset), .FunSel(FunSel1), .I(I1), .RegEn(RegEn1),
    .OutASel(OutASel1), .OutBSel(OutBSel1), .OutA(OutA1), .OutB(OutB1),
    .Zero(Zero1), .Carry(Carry1)
  );

  typedef struct {
    bit          dut;
    logic [15:0] ea;
    logic [15:0] eb;
    bit          cf;
    bit          ez;
    bit          ec;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per falling edge, compared against live outputs.
  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.dut) begin
        check({e.tag, ".A"}, OutA0, e.ea);
        check({e.tag, ".B"}, OutB0, e.eb);
        if (e.cf) begin
          check({e.tag, ".Z"}, {15'b0, Zero0}, {15'b0, e.ez});
          check({e.tag, ".C"}, {15'b0, Carry0}, {15'b0, e.ec});
        end
      end else begin
        check({e.tag, ".A"}, {8'h00, OutA1}, e.ea);
        check({e.tag, ".B"}, {8'h00, OutB1}, e.eb);
        if (e.cf) begin
          check({e.tag, ".Z"}, {15'b0, Zero1}, {15'b0, e.ez});
          check({e.tag, ".C"}, {15'b0, Carry1}, {15'b0, e.ec});
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
    FunSel0 = FS_HOLD; RegEn0 = '0;
    FunSel1 = FS_HOLD; RegEn1 = '0;
  endtask

  task automatic apply0(input funsel_t fs, input logic [3:0] en, input logic [15:0] din);
    FunSel0 = fs; RegEn0 = en; I0 = din;
    step();
  endtask

  task automatic apply1(input funsel_t fs, input logic [2:0] en, input logic [7:0] din);
    FunSel1 = fs; RegEn1 = en; I1 = din;
    step();
  endtask

  task automatic push(input bit dut, input logic [1:0] sa, input logic [1:0] sb_sel,
                      input logic [15:0] ea, input logic [15:0] eb,
                      input bit cf, input bit ez, input bit ec, input string tag);
    exp_t e;
    if (!dut) begin OutASel0 = sa; OutBSel0 = sb_sel; end
    else      begin OutASel1 = sa; OutBSel1 = sb_sel; end
    e.dut = dut; e.ea = ea; e.eb = eb; e.cf = cf; e.ez = ez; e.ec = ec; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_rd(input bit dut, input logic [1:0] sa, input logic [1:0] sb_sel,
                           input logic [15:0] ea, input logic [15:0] eb,
                           input bit cf, input bit ez, input bit ec, input string tag);
    push(dut, sa, sb_sel, ea, eb, cf, ez, ec, tag);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    step();
    expect_rd(0, 0, 1, 16'h00A5, 16'h00A5, 1, 0, 0, "por_r0r1");

    // Drive flags to 1/1 and registers to 0 so the reset below is visible
    apply0(FS_LOAD, 4'b1111, 16'hFFFF);
    apply0(FS_INC,  4'b1111, 16'h0000);
    expect_rd(0, 2, 3, 16'h0000, 16'h0000, 1, 1, 1, "inc_all_wrap");

    // Asynchronous reset in the middle of a LOAD cycle
    FunSel0 = FS_LOAD; RegEn0 = 4'b1111; I0 = 16'h1234;
    #2 Reset = 1'b0;
    push(0, 0, 1, 16'h00A5, 16'h00A5, 1, 0, 0, "rst_async_r0r1");
    step();
    push(0, 2, 3, 16'h00A5, 16'h00A5, 1, 0, 0, "rst_async_r2r3");
    step();
    Reset = 1'b1;
    step();

    // INC/DEC wrap on R1
    apply0(FS_LOAD, 4'b0010, 16'hFFFF);
    apply0(FS_INC,  4'b0010, 16'h0000);
    expect_rd(0, 1, 0, 16'h0000, 16'h00A5, 1, 1, 1, "r1_inc");
    apply0(FS_DEC,  4'b0010, 16'h0000);
    expect_rd(0, 1, 0, 16'hFFFF, 16'h00A5, 1, 0, 1, "r1_dec");

    // Half-word writes, swap and sign-extending load on R2
    apply0(FS_LOAD,   4'b0100, 16'h1234);
    apply0(FS_WRHI,   4'b0100, 16'h00AB);
    expect_rd(0, 2, 2, 16'hAB34, 16'hAB34, 1, 0, 0, "r2_wrhi");
    apply0(FS_WRLO,   4'b0100, 16'h00CD);
    expect_rd(0, 2, 2, 16'hABCD, 16'hABCD, 0, 0, 0, "r2_wrlo");
    apply0(FS_SWAP,   4'b0100, 16'h0000);
    expect_rd(0, 2, 2, 16'hCDAB, 16'hCDAB, 0, 0, 0, "r2_swap");
    apply0(FS_LOADLS, 4'b0100, 16'h0080);
    expect_rd(0, 2, 1, 16'hFF80, 16'hFFFF, 1, 0, 0, "r2_loadls");

    // Shift/rotate chain on R0
    apply0(FS_LOAD, 4'b0001, 16'h8001);
    apply0(FS_ASR,  4'b0001, 16'h0000);
    expect_rd(0, 0, 0, 16'hC000, 16'hC000, 1, 0, 1, "r0_asr");
    apply0(FS_ROL,  4'b0001, 16'h0000);
    expect_rd(0, 0, 0, 16'h8001, 16'h8001, 1, 0, 1, "r0_rol");
    apply0(FS_SHR,  4'b0001, 16'h0000);
    expect_rd(0, 0, 0, 16'h4000, 16'h4000, 1, 0, 1, "r0_shr");
    apply0(FS_SHL,  4'b0001, 16'h0000);
    expect_rd(0, 0, 0, 16'h8000, 16'h8000, 1, 0, 0, "r0_shl");

    // Two enabled registers; flags come from R1, the lower index
    apply0(FS_CLEAR, 4'b0010, 16'h0000);
    apply0(FS_LOAD,  4'b1000, 16'h0005);
    apply0(FS_DEC,   4'b1010, 16'h0000);
    expect_rd(0, 1, 3, 16'hFFFF, 16'h0004, 1, 0, 1, "multi_dec");
    expect_rd(0, 0, 2, 16'h8000, 16'hFF80, 0, 0, 0, "multi_untouched");

    // Read ports show pre-edge value during a LOAD, new value after
    FunSel0 = FS_LOAD; RegEn0 = 4'b0010; I0 = 16'h5A5A;
    push(0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, "no_bypass_pre");
    step();
    expect_rd(0, 1, 1, 16'h5A5A, 16'h5A5A, 1, 0, 0, "no_bypass_post");

    // HOLD, reserved and RegEn=0 leave registers and flags alone
    apply0(FS_CLEAR, 4'b0001, 16'h0000);
    apply0(FS_DEC,   4'b0001, 16'h0000);
    apply0(FS_HOLD,  4'b1111, 16'h0000);
    apply0(FS_RSVD,  4'b1111, 16'h0000);
    apply0(FS_LOAD,  4'b0000, 16'h0000);
    expect_rd(0, 0, 1, 16'hFFFF, 16'h5A5A, 1, 0, 1, "hold_r0r1");
    expect_rd(0, 2, 3, 16'hFF80, 16'h0004, 1, 0, 1, "hold_r2r3");

    // 8-bit, 3-register build: out-of-range select and INC wrap
    apply1(FS_LOAD, 3'b111, 8'h7E);
    apply1(FS_LOAD, 3'b010, 8'hFF);
    apply1(FS_INC,  3'b010, 8'h00);
    expect_rd(1, 3, 2, 16'h0000, 16'h007E, 1, 1, 1, "w8_sel3_inc");
    expect_rd(1, 0, 1, 16'h007E, 16'h0000, 0, 0, 0, "w8_r0r1");

    step();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
